seq_divider: RTL and testbench

- Iterative restoring divider; the inverse of the adder datapath. Computes quotient and remainder one bit per clock.
- Each trial subtraction uses a carry-lookahead subtractor sub-module: a + ~b + 1, with carry-out meaning no borrow.
- Stand-alone arithmetic unit for the Goldschmidt division work. Used as the exact reference/fallback divider and for reciprocal-seed generation.
- Start/busy/done handshake toward the controlling FSM.

---
 rtl/seq_divider_pkg.sv | 18 +
 rtl/seq_divider_cla_sub.sv | 38 +++
 rtl/seq_divider.sv | 158 +++++++++++++++
 tb/tb_seq_divider.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings,
// default operand width and the iteration-counter width helper.
package seq_divider_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Counter must be able to hold the value WIDTH itself.
   function automatic int count_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_divider_cla_sub.sv
// Parameterised carry-lookahead subtractor computing a + ~b + 1 with a
// Kogge-Stone prefix network; no_borrow is the final carry-out.
module cla_sub #(
   parameter int W = 9
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         no_borrow
);

   logic [W-1:0] bn;
   logic [W-1:0] p;
   logic [W-1:0] g;
   logic [W-1:0] carry;

   // Bit 0 absorbs the +1 carry-in so the prefix tree needs no separate cin.
   always_comb begin
      logic [W-1:0] gp;
      logic [W-1:0] pp;
      bn = ~b;
      p  = a ^ bn;
      g  = a & bn;
      gp = g;
      pp = p;
      gp[0] = g[0] | p[0];
      for (int d = 1; d < W; d = d * 2) begin
         for (int i = W - 1; i >= d; i--) begin
            gp[i] = gp[i] | (pp[i] & gp[i-d]);
            pp[i] = pp[i] & pp[i-d];
         end
      end
      carry     = {gp[W-2:0], 1'b1};
      diff      = p ^ carry;
      no_borrow = gp[W-1];
   end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done
// handshake. Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = count_width(WIDTH);

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   prem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic             accept;
   logic             divisor_zero;
   logic             last_iter;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             no_borrow;
   logic [WIDTH:0]   prem_next;
   logic [WIDTH-1:0] dvd_next;
   logic [WIDTH-1:0] q_result;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic neg_q;
   logic neg_r;
`endif

   assign accept       = (state == S_IDLE) && start;
   assign divisor_zero = (divisor == '0);
   assign last_iter    = (count == CW'(WIDTH - 1));

   // The dividend register doubles as the quotient shift register.
   always_comb begin
      shifted = (prem << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};
   end

   cla_sub #(
      .W(WIDTH + 1)
   ) u_sub (
      .a        (shifted),
      .b        ({1'b0, dvs}),
      .diff     (diff),
      .no_borrow(no_borrow)
   );

   always_comb begin
      prem_next = no_borrow ? diff : shifted;
      dvd_next  = {dvd[WIDTH-2:0], no_borrow};
   end

`ifdef SEQ_DIVIDER_SIGNED_EN
   // Divide magnitudes, then restore signs; -min/-1 wraps back to min by itself.
   always_comb begin
      dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
      divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
      q_result     = neg_q ? -dvd_next : dvd_next;
      r_result     = neg_r ? -prem_next[WIDTH-1:0] : prem_next[WIDTH-1:0];
   end
`else
   always_comb begin
      dividend_mag = dividend;
      divisor_mag  = divisor;
      q_result     = dvd_next;
      r_result     = prem_next[WIDTH-1:0];
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_next = divisor_zero ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (last_iter) begin
               state_next = S_DONE;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_CALC);
      done = (state == S_DONE);
   end

   // Result registers only move on the edge that enters DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count       <= '0;
         prem        <= '0;
         dvd         <= '0;
         dvs         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else if (accept) begin
         if (divisor_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end else begin
            dvd         <= dividend_mag;
            dvs         <= divisor_mag;
            prem        <= '0;
            count       <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r       <= dividend[WIDTH-1];
`endif
         end
      end else if (state == S_CALC) begin
         prem  <= prem_next;
         dvd   <= dvd_next;
         count <= count + 1'b1;
         if (last_iter) begin
            quotient  <= q_result;
            remainder <= r_result;
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (unsigned build): directed literal cases
// plus randomized traffic compared every cycle against a behavioural model.
module tb_seq_divider;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int tests_run;
   int tests_failed;

   logic [W-1:0] m_q;
   logic [W-1:0] m_r;
   logic         m_dz;
   logic         m_done;
   int           m_left;
   logic [W-1:0] pend_q;
   logic [W-1:0] pend_r;

   seq_divider #(
      .WIDTH(W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an operation is a countdown of W busy cycles, results from / and %.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q    <= '0;
         m_r    <= '0;
         m_dz   <= 1'b0;
         m_done <= 1'b0;
         m_left <= 0;
         pend_q <= '0;
         pend_r <= '0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_left > 1) begin
         m_left <= m_left - 1;
      end else if (m_left == 1) begin
         m_left <= 0;
         m_done <= 1'b1;
         m_q    <= pend_q;
         m_r    <= pend_r;
      end else if (start) begin
         if (divisor == 0) begin
            m_done <= 1'b1;
            m_q    <= '1;
            m_r    <= dividend;
            m_dz   <= 1'b1;
         end else begin
            m_left <= W;
            m_dz   <= 1'b0;
            pend_q <= dividend / divisor;
            pend_r <= dividend % divisor;
         end
      end
   end

   always @(negedge clk) begin
      check_output("busy", 32'(busy), 32'(m_left > 0));
      check_output("done", 32'(done), 32'(m_done));
      check_output("quotient", 32'(quotient), 32'(m_q));
      check_output("remainder", 32'(remainder), 32'(m_r));
      check_output("div_by_zero", 32'(div_by_zero), 32'(m_dz));
   end

   // One operation from an idle divider; latency counted in cycles after the accept edge.
   task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                                 input logic exp_dz, input int exp_lat);
      int lat;
      int busy_cycles;
      lat = 0;
      busy_cycles = 0;
      @(posedge clk); #2;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk); #2;
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      for (int k = 1; k <= W + 6; k++) begin
         @(negedge clk);
         if (busy) busy_cycles++;
         if (done) begin
            lat = k;
            break;
         end
      end
      check_output($sformatf("latency %0d/%0d", a, b), 32'(lat), 32'(exp_lat));
      check_output($sformatf("busy cycles %0d/%0d", a, b), 32'(busy_cycles), 32'(exp_lat - 1));
      check_output($sformatf("q %0d/%0d", a, b), 32'(quotient), 32'(exp_q));
      check_output($sformatf("r %0d/%0d", a, b), 32'(remainder), 32'(exp_r));
      check_output($sformatf("dz %0d/%0d", a, b), 32'(div_by_zero), 32'(exp_dz));
   endtask

   initial begin
      int done_pulses;
      tests_run    = 0;
      tests_failed = 0;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset busy", 32'(busy), 32'd0);
      check_output("reset done", 32'(done), 32'd0);
      check_output("reset quotient", 32'(quotient), 32'd0);
      check_output("reset remainder", 32'(remainder), 32'd0);
      check_output("reset dz", 32'(div_by_zero), 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;

      apply_stimulus(8'hFE, 8'h06, 8'd42, 8'd2, 1'b0, W + 1);
      apply_stimulus(8'd7, 8'd0, 8'hFF, 8'd7, 1'b1, 1);
      apply_stimulus(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, W + 1);
      apply_stimulus(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, W + 1);

      // A second start during the operation must be ignored.
      @(posedge clk); #2;
      start = 1'b1; dividend = 8'd200; divisor = 8'd7;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      start = 1'b1; dividend = 8'd10; divisor = 8'd3;
      @(posedge clk); #2;
      start = 1'b0;
      done_pulses = 0;
      for (int k = 0; k < W + 8; k++) begin
         @(negedge clk);
         if (done) begin
            done_pulses++;
            check_output("ignored start q", 32'(quotient), 32'd28);
            check_output("ignored start r", 32'(remainder), 32'd4);
         end
      end
      check_output("ignored start done pulses", 32'(done_pulses), 32'd1);

      // Reset in the middle of a calculation aborts it silently.
      @(posedge clk); #2;
      start = 1'b1; dividend = 8'd100; divisor = 8'd3;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_output("abort busy", 32'(busy), 32'd0);
      check_output("abort quotient", 32'(quotient), 32'd0);
      check_output("abort remainder", 32'(remainder), 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      done_pulses = 0;
      for (int k = 0; k < W + 6; k++) begin
         @(negedge clk);
         if (done) done_pulses++;
      end
      check_output("abort done pulses", 32'(done_pulses), 32'd0);
      apply_stimulus(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, W + 1);

      // Randomized traffic, including held starts, zero divisors and resets.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #2;
         start    = ($urandom_range(0, 99) < 35);
         dividend = W'($urandom);
         divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         rst      = ($urandom_range(0, 299) == 0);
      end
      @(posedge clk); #2;
      rst   = 1'b0;
      start = 1'b0;
      repeat (W + 4) @(posedge clk);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
